// File: rtl/secret_decoder.sv
// secret_decoder: recovers one 16-bit hidden chunk per 4x4 block of a 64x64 image pair.
// Optional build macro SECRET_DEC_ERR_CHECK_EN enables the sticky err flag.
//
// state  | meaning
// IDLE   | waiting for start, address parked at (0,0)
// FIND   | scan reference block for base value and second position P2
// DECODE | accumulate base-3 digits from the 14 carrier slots
// EMIT   | word_valid held high until word_ready
// NEXT   | step to the next block origin, or finish after block 255
// DONE   | one-cycle decode_done pulse
module secret_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [5:0]  row,
  output logic [5:0]  col,
  input  logic [23:0] ref_pix,
  input  logic [23:0] enc_pix,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] word_data,
  output logic [7:0]  word_idx,
  output logic        decode_done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, FIND, DECODE, EMIT, NEXT, DONE} state_t;

  state_t      state;
  logic [3:0]  pos;
  logic [3:0]  p2;
  logic [7:0]  base;
  logic [22:0] acc;
  logic [22:0] weight;

  logic [7:0]  ref_gray;
  logic [7:0]  enc_gray;
  logic [7:0]  diff;
  logic [3:0]  pos_inc;
  logic [7:0]  idx_inc;
  logic        is_slot;
  logic [1:0]  digit;
  logic [22:0] term;
  logic [22:0] acc_next;
  logic        unused_pix;

  assign ref_gray   = ref_pix[15:8];
  assign enc_gray   = enc_pix[15:8];
  assign diff       = enc_gray - ref_gray;
  assign pos_inc    = pos + 4'd1;
  assign idx_inc    = word_idx + 8'd1;
  assign is_slot    = (pos != 4'd0) && (pos != p2);
  assign unused_pix = ^{ref_pix[23:16], ref_pix[7:0], enc_pix[23:16], enc_pix[7:0]};

  // Only +1 / -1 mod 256 carry a digit; anything else reads as 0.
  always_comb begin
    digit = 2'd0;
    case (diff)
      8'h01:   digit = 2'd1;
      8'hFF:   digit = 2'd2;
      default: digit = 2'd0;
    endcase
  end

  always_comb begin
    term = '0;
    if (is_slot) begin
      case (digit)
        2'd1:    term = weight;
        2'd2:    term = {weight[21:0], 1'b0};
        default: term = '0;
      endcase
    end
  end

  assign acc_next = acc + term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      pos         <= '0;
      p2          <= '0;
      base        <= '0;
      acc         <= '0;
      weight      <= 23'd1;
      word_valid  <= 1'b0;
      word_data   <= '0;
      word_idx    <= '0;
      decode_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FIND;
            row      <= '0;
            col      <= '0;
            pos      <= '0;
            word_idx <= '0;
            acc      <= '0;
            weight   <= 23'd1;
          end
        end

        FIND: begin
          if (pos == 4'd0) base <= ref_gray;
          if ((pos != 4'd0 && ref_gray != base) || pos == 4'd15) begin
            // A fully uniform block falls back to P2 at raster index 1.
            p2    <= (pos != 4'd0 && ref_gray != base) ? pos : 4'd1;
            state <= DECODE;
            pos   <= '0;
            row   <= {word_idx[7:4], 2'b00};
            col   <= {word_idx[3:0], 2'b00};
          end else begin
            pos <= pos_inc;
            row <= {word_idx[7:4], pos_inc[3:2]};
            col <= {word_idx[3:0], pos_inc[1:0]};
          end
        end

        DECODE: begin
          if (is_slot) begin
            acc    <= acc_next;
            weight <= weight + {weight[21:0], 1'b0};
          end
          if (pos == 4'd15) begin
            state      <= EMIT;
            word_valid <= 1'b1;
            word_data  <= acc_next[15:0];
          end else begin
            pos <= pos_inc;
            row <= {word_idx[7:4], pos_inc[3:2]};
            col <= {word_idx[3:0], pos_inc[1:0]};
          end
        end

        EMIT: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            state      <= NEXT;
          end
        end

        NEXT: begin
          if (word_idx == 8'd255) begin
            state       <= DONE;
            decode_done <= 1'b1;
          end else begin
            state    <= FIND;
            word_idx <= idx_inc;
            row      <= {idx_inc[7:4], 2'b00};
            col      <= {idx_inc[3:0], 2'b00};
            pos      <= '0;
            acc      <= '0;
            weight   <= 23'd1;
          end
        end

        DONE: begin
          decode_done <= 1'b0;
          row         <= '0;
          col         <= '0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SECRET_DEC_ERR_CHECK_EN
  logic slot_bad;
  logic acc_ovf;

  assign slot_bad = (state == DECODE) && is_slot && (diff != 8'h00) && (digit == 2'd0);
  assign acc_ovf  = (state == DECODE) && (pos == 4'd15) && (|acc_next[22:16]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err <= 1'b0;
    else if (state == IDLE && start) err <= 1'b0;
    else if (slot_bad || acc_ovf)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/secret_decoder.md
# secret_decoder

Extraction stage downstream of the steganographic encoder. It walks a 64x64 image pair, taking the compressed image as reference and the encoded image as carrier, in 4x4 blocks in row-major block order. For each block it recovers the 16-bit chunk of the hidden string that the encoder embedded there. It then emits that chunk on a valid/ready word stream: 256 words in total, covering the full 8x512-bit secret.

## Interface
- No parameters; image size (64x64), block size (4x4) and word width (16) are fixed.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; begins decoding when idle.
- row  out  6  row address driven to both image memories.
- col  out  6  column address driven to both image memories.
- ref_pix  in  24  compressed-image pixel at [row,col], combinational read; gray value in [15:8].
- enc_pix  in  24  encoded-image pixel at [row,col], combinational read; gray value in [15:8].
- word_valid  out  1  word_data/word_idx hold a decoded chunk.
- word_ready  in  1  consumer accepts the word when high together with word_valid.
- word_data  out  16  decoded chunk; bit 0 = hiding_string bit 16*word_idx.
- word_idx  out  8  block index 0..255, equal to (row/4)*16 + col/4 of the block origin.
- decode_done  out  1  one-cycle pulse after word 255 is accepted.
- err  out  1  sticky decode-error flag; active only with SECRET_DEC_ERR_CHECK_EN.

## Operation
- Registered FSM states: IDLE, FIND, DECODE, EMIT, NEXT, DONE.
- IDLE: row = col = 0. start -> FIND with block origin (0,0), word_idx = 0, err cleared. start in any other state is ignored.
- FIND: scans the block's reference pixels in raster order (origin, then +1 column up to +3, then next row), one pixel per cycle.
  - The origin value becomes the base value.
  - The first pixel whose ref_pix[15:8] differs from the base value is recorded as the second position (P2), and the state moves to DECODE.
  - If all 16 pixels are equal, P2 = (origin row, origin col + 1).
- DECODE: scans all 16 positions in raster order, one per cycle, skipping the origin and P2. The 14 remaining positions are carrier slots k = 0..13.
  - Per slot: diff = enc[15:8] - ref[15:8], taken modulo 256.
  - 8'h00 -> digit 0, 8'h01 -> digit 1, 8'hFF -> digit 2.
  - Accumulator (23 bits) += digit * weight. Weight starts at 1 and is multiplied by 3 after each slot, so slot k has weight 3^k. Digits are therefore consumed LSB first.
  - After slot 13: word_data = acc[15:0], then go to EMIT.
- EMIT: word_valid = 1, with word_data and word_idx held stable. When word_ready is seen, go to NEXT.
- NEXT:
  - If word_idx == 255, go to DONE.
  - Otherwise advance the origin: col += 4. If the old col was 60, col = 0 and row += 4.
  - Increment word_idx, clear the accumulator, and go to FIND.
- DONE: decode_done = 1 for one cycle, then go to IDLE.

## Timing
- Reset values: row = 0, col = 0, word_valid = 0, word_data = 0, word_idx = 0, decode_done = 0, err = 0; state = IDLE.
- Reset mid-operation: the operation is abandoned immediately, with no partial word emitted.
- Addresses are registered. ref_pix/enc_pix are sampled in the same cycle that row/col present the address.
- Per-block latency:
  - FIND takes n+1 cycles, where n is the raster index of P2 (1..15). With no distinct pixel, FIND takes 16 cycles.
  - DECODE takes 16 cycles, EMIT takes at least 1 cycle, NEXT takes 1 cycle.
  - Worst case is 34 cycles per block at word_ready = 1.
- word_valid rises on the cycle after the last DECODE cycle. It falls on the cycle after a ready handshake.
- Backpressure: while word_ready is low, the FSM stalls in EMIT indefinitely and all outputs stay stable.

## Configuration
- SECRET_DEC_ERR_CHECK_EN defined:
  - A diff outside {00, 01, FF} sets err and decodes as digit 0.
  - A final acc > 16'hFFFF also sets err.
  - err stays set until the next accepted start or reset.
- Not defined: err is tied 0, out-of-range diffs decode as digit 0, and overflow is silently truncated to acc[15:0].

## Test plan
- Uniform image: ref = enc = 0x80 everywhere, start -> 256 words of 0x0000, word_idx 0..255 in order. P2 = (0,1) for every block, and decode_done pulses once.
- Block 0: ref 0x40 except (1,2) = 0xC0, so P2 = (1,2). enc = ref+1 at (0,1), all other slots equal -> word 0 = 0x0001.
- Block 0 slots 0..10 with digits 0,2,0,0,2,2,2,2,0,0,1 (as FF/01 diffs), remaining slots 0 -> word 0 = 0xFFFF, err = 0.
- Modular wrap: slot 0 ref 0xFF / enc 0x00 -> digit 1. slot 1 ref 0x00 / enc 0xFF -> digit 2. Word = 1 + 2*3 = 0x0007.
- Backpressure: word_ready low for 5 cycles at word 0 -> word_valid stays high, data/idx stable, row/col unchanged. Word 1 is emitted only after acceptance.
- Error/reset: slot diff 0x02 -> err = 1 with the macro, err = 0 and digit 0 without it. Asserting rst during DECODE of block 7 -> all outputs at reset values; a subsequent start restarts from word 0.
